// File: rtl/data_mem_pkg.sv
// data_mem_pkg
//   Shared encodings and lane helpers for the data-memory slave.
//   - mode_e  : bus transfer mode (idle / read / write / reserved)
//   - size_e  : transfer size (byte / half / word / reserved)
//   - state_e : controller FSM states
//   - swap_lanes, norm_size, is_misaligned, load_extract, store_merge
//
// "Logical" word: byte at offset k sits in bits [8k+7:8k]. The RAM holds
// the logical word byte-reversed when the controller is big-endian.
package data_mem_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RD_DONE   = 2'b01,
        ST_RMW_WRITE = 2'b10
    } state_e;

    // Converts between RAM and logical byte order (the swap is its own inverse).
    function automatic logic [31:0] swap_lanes(input logic [31:0] w, input bit big_endian);
        return big_endian ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    // The reserved size encoding behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] s);
        return (s == SIZE_RSVD) ? SIZE_WORD : size_e'(s);
    endfunction

    function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
        case (s)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

    // Picks the addressed byte/half out of a logical word and extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] lw, input logic [1:0] off,
                                                 input size_e s, input logic zero_ext);
        logic [31:0] sh;
        sh = lw >> {off, 3'b000};
        case (s)
            SIZE_BYTE: return {{24{~zero_ext & sh[7]}}, sh[7:0]};
            SIZE_HALF: return {{16{~zero_ext & sh[15]}}, sh[15:0]};
            default:   return lw;
        endcase
    endfunction

    // Replaces the addressed byte/half of a logical word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] lw, input logic [1:0] off,
                                                input size_e s, input logic [31:0] data);
        logic [31:0] mask;
        logic [31:0] val;
        case (s)
            SIZE_BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                val  = {24'h0, data[7:0]} << {off, 3'b000};
            end
            SIZE_HALF: begin
                mask = 32'h0000_FFFF << {off, 3'b000};
                val  = {16'h0, data[15:0]} << {off, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                val  = data;
            end
        endcase
        return (lw & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// ram_sp
//   Single-port synchronous word RAM, 32 bits wide.
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous active-low reset (read register only)
//     addr   in   word address
//     we     in   write enable, write happens at the clock edge
//     re     in   read enable, rdata is loaded at the clock edge
//     wdata  in   write data
//     rdata  out  registered read data, holds between reads
module ram_sp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; a reset loop over every word would
    // prevent block-RAM inference, and stored data must survive reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data-memory slave on the shared data bus. Decodes an address window and
//   serves byte/half/word loads (sign- or zero-extended) and stores.
//   Sub-word stores are read-modify-write over a single-port word RAM.
//   Ports:
//     clk                in     clock
//     reset              in     asynchronous active-low reset
//     data_bus_addr      in     byte address
//     data_bus_mode      in     00 idle, 01 read, 10 write, 11 idle
//     data_bus_size      in     00 byte, 01 half, 10/11 word
//     data_bus_unsigned  in     1 zero-extends sub-word loads
//     data_bus_data      inout  store data in, load data out, else high-Z
//     busy               out    stall request (multi-cycle access pending)
//     err                out    misaligned access flag
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_size,
    input  logic        data_bus_unsigned,
    inout  wire  [31:0] data_bus_data,
    output logic        busy,
    output logic        err
);

    localparam int          ADDR_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    // Decode
    logic [31:0]       offset;
    logic              in_window;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    mode_e             mode;
    size_e             size;
    logic              is_read;
    logic              is_write;
    logic              sel;
    logic              misaligned;
    logic [31:0]       bus_in;

    // Window check uses a 33-bit compare so a window ending at 4 GiB works.
    assign offset     = data_bus_addr - BASE_ADDR;
    assign in_window  = (data_bus_addr >= BASE_ADDR) && ({1'b0, offset} < WINDOW_BYTES);
    assign word_idx   = offset[ADDR_W+1:2];
    assign byte_off   = data_bus_addr[1:0];
    assign mode       = mode_e'(data_bus_mode);
    assign size       = norm_size(data_bus_size);
    assign is_read    = (mode == MODE_READ);
    assign is_write   = (mode == MODE_WRITE);
    assign sel        = in_window && (is_read || is_write);
    assign misaligned = is_misaligned(size, byte_off);
    assign bus_in     = data_bus_data;

    // FSM
    state_e      state;
    state_e      state_next;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] ram_logical;

    assign ram_logical = swap_lanes(ram_rdata, BIG_ENDIAN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        err        = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    if (misaligned) begin
                        err = 1'b1;
                    end else if (is_read) begin
                        ram_re     = 1'b1;
                        busy       = 1'b1;
                        state_next = ST_RD_DONE;
                    end else if (size == SIZE_WORD) begin
                        ram_we    = 1'b1;
                        ram_wdata = swap_lanes(bus_in, BIG_ENDIAN);
                    end else begin
                        ram_re     = 1'b1;
                        busy       = 1'b1;
                        state_next = ST_RMW_WRITE;
                    end
                end
            end
            ST_RD_DONE: begin
                state_next = ST_IDLE;
            end
            ST_RMW_WRITE: begin
                // A dropped request abandons the merge without touching RAM.
                if (sel && is_write) begin
                    ram_we    = 1'b1;
                    ram_wdata = swap_lanes(store_merge(ram_logical, byte_off, size, bus_in),
                                           BIG_ENDIAN);
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    ram_sp #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .addr (word_idx),
        .we   (ram_we),
        .re   (ram_re),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Bus drive: the load value in RD_DONE, or zero for a misaligned read.
    logic        bus_drive;
    logic [31:0] bus_out;

    assign bus_drive     = sel && is_read && !busy;
    assign bus_out       = (state == ST_RD_DONE)
                           ? load_extract(ram_logical, byte_off, size, data_bus_unsigned)
                           : 32'h0;
    assign data_bus_data = bus_drive ? bus_out : 32'bz;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory slave on the core's shared data bus. It decodes a configurable address window and serves word, half-word and byte loads and stores, with sign/zero extension on loads. Sub-word stores use read-modify-write over a single-port word RAM. It drives `busy` so the pipeline stalls on multi-cycle accesses, and supersedes the fixed 4 KiB word-only data memory.

## Interface
- `BASE_ADDR`, default 32'h2000: first byte address of the window; must be 4-byte aligned.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; power of two. The window is `BASE_ADDR` to `BASE_ADDR + 4*DEPTH_WORDS - 1`.
- `BIG_ENDIAN`, default 1: 1 stores the byte at the lowest address in RAM bits [31:24]; 0 stores it in bits [7:0].
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `data_bus_addr`  in  32  byte address.
- `data_bus_mode`  in  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- `data_bus_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `data_bus_unsigned`  in  1  1 zero-extends sub-word loads; 0 sign-extends them.
- `data_bus_data`  inout  32  store data in; load data out; high-Z otherwise.
- `busy`  out  1  stall request to the requester.
- `err`  out  1  one-cycle misaligned-access flag.

## Operation
- `sel` = address inside the window and mode is 01 or 10. Word index = (`data_bus_addr` - `BASE_ADDR`)[clog2(DEPTH_WORDS)+1:2]. Byte offset = addr[1:0].
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - No RAM access takes place.
  - `err`=1 and `busy`=0 in that cycle.
  - A read drives 32'h0 on the bus.
- Register lane for byte offset k is `BIG_ENDIAN` ? 3-k : k. Half-word lanes follow the same mapping. Word stores are byte-reversed when `BIG_ENDIAN`=1.
- FSM states: IDLE, RD_DONE, RMW_WRITE.
  - IDLE, aligned read: RAM read issued, `busy`=1, next state RD_DONE.
  - IDLE, aligned word write: RAM written at the edge, `busy`=0, stay in IDLE.
  - IDLE, aligned byte/half write: RAM read issued, `busy`=1, next state RMW_WRITE.
  - RD_DONE: `busy`=0. Drive the extracted and extended load value on `data_bus_data` from the registered RAM word. Next state IDLE.
  - RMW_WRITE: `busy`=0. Merge the store lanes into the registered RAM word and write it at the edge. Next state IDLE.
- Requester rule: hold addr, mode, size, unsigned and store data stable until it samples `busy`=0. The transaction completes at that edge.
- Abort rule: if `sel` drops while in RD_DONE or RMW_WRITE, return to IDLE with no write and no bus drive.
- The bus is driven only when `sel`, mode is 01 and `busy`=0 (including the misaligned zero). Otherwise it is high-Z.

## Timing
- Reset (asynchronous) forces: state IDLE, `busy`=0, `err`=0, bus high-Z, load register 0. RAM contents are not cleared.
- Latency:
  - Word write: 1 cycle.
  - Load: 2 cycles; data is valid in the cycle after request acceptance.
  - Sub-word write: 2 cycles.
  - Misaligned access: 1 cycle.
- `busy` and `err` are combinational from state and bus inputs.
- RAM is synchronous: read data is registered at the edge, write happens at the edge. A write and a read never occur in the same cycle.
- Reset asserted in RD_DONE or RMW_WRITE: the pending write is discarded and state is IDLE on release.
- Back-to-back accesses: a new request is evaluated in the IDLE cycle directly after completion. No bubble is needed.

## Structure
- Package `data_mem_pkg`:
  - mode encodings (IDLE/READ/WRITE);
  - size encodings (BYTE/HALF/WORD);
  - FSM state enum;
  - lane-select and extend helper functions.
- Sub-module `ram_sp`:
  - parameters `DEPTH_WORDS` and 32-bit width;
  - single port: `addr`, `we`, `re`, `wdata`, registered `rdata`;
  - no reset on the array, so it infers block RAM.
- Top level holds decode, FSM, lane merge/extract and tristate.

## Test plan
- Word write 0x11223344 @0x2004, then word read @0x2004 → `busy` 1 for one cycle, then bus reads 0x11223344. With `BIG_ENDIAN`=1, RAM word 1 = 0x44332211.
- After the above, byte store 0xAA @0x2005 → `busy` 1,0; word read @0x2004 returns 0x1122AA44.
- Byte load @0x2005 with unsigned=0 → 0xFFFFFFAA; with unsigned=1 → 0x000000AA. Half load @0x2006 with unsigned=0 → 0x00001122.
- Half read @0x2003 → `err`=1 for one cycle, `busy`=0, bus 0x0, RAM unchanged.
- Read @0x3000 (default params) → bus high-Z, `busy`=0, `err`=0. Write @0x1FFC → no RAM change.
- Byte store 0x55 @0x2008, reset pulsed during RMW_WRITE → word read @0x2008 returns the prior contents, FSM is IDLE.
